// File: rtl/riscv_fetch_unit_if.sv
// Signal bundle for the fetch unit: instruction-memory request/response, core redirect
// and the instruction handshake. master = fetch unit, slave = memory/core side.
interface riscv_fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_req_addr;
   logic            mem_resp_valid;
   logic [XLEN-1:0] mem_resp_data;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic [XLEN-1:0] instruction;
   logic [XLEN-1:0] instr_addr;
   logic            exception;

   modport master (
      output mem_req_valid, mem_req_addr, instr_valid, instruction, instr_addr, exception,
      input  mem_req_ready, mem_resp_valid, mem_resp_data, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, instr_valid, instruction, instr_addr, exception,
      output mem_req_ready, mem_resp_valid, mem_resp_data, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/riscv_fetch_unit.sv
// RV32I fetch/prefetch stage: issues word-aligned fetches, buffers in-order responses in a
// small FIFO and hands {instruction, pc} to the core; redirects flush and squash in-flight data.
module riscv_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   riscv_fetch_unit_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = CW + 1;

   logic [XLEN-1:0] r_fetchPc;
   logic [XLEN-1:0] r_pcTag;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   r_inflight;
   logic [CW-1:0]   r_drop;
   logic [PW-1:0]   r_rdPtr;
   logic [PW-1:0]   r_wrPtr;
   logic            r_exception;
   logic [XLEN-1:0] r_fifoInstr [DEPTH];
   logic [XLEN-1:0] r_fifoAddr  [DEPTH];

   logic            w_valid;
   logic            w_reqFire;
   logic            w_respIn;
   logic            w_push;
   logic            w_pop;
   logic [OW-1:0]   w_occupancy;

   // FIFO slots are reserved at request time, so a full FIFO plus outstanding fetches never overflows.
   assign w_occupancy       = {1'b0, r_count} + {1'b0, r_inflight};
   assign bus.mem_req_valid = !rst && !bus.redirect && !r_exception && (w_occupancy < OW'(DEPTH));
   assign bus.mem_req_addr  = r_fetchPc;
   assign w_reqFire         = bus.mem_req_valid && bus.mem_req_ready;

   // A response with nothing outstanding is ignored so the counters cannot underflow.
   assign w_respIn = bus.mem_resp_valid && (r_inflight != '0);
   assign w_push   = w_respIn && (r_drop == '0) && !bus.redirect;
   assign w_valid  = (r_count != '0);
   assign w_pop    = w_valid && bus.instr_ready && !bus.redirect;

   assign bus.instr_valid = w_valid;
   assign bus.instruction = w_valid ? r_fifoInstr[r_rdPtr] : '0;
   assign bus.instr_addr  = w_valid ? r_fifoAddr[r_rdPtr]  : '0;
   assign bus.exception   = r_exception;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetchPc   <= RESET_PC;
         r_pcTag     <= RESET_PC;
         r_count     <= '0;
         r_inflight  <= '0;
         r_drop      <= '0;
         r_rdPtr     <= '0;
         r_wrPtr     <= '0;
         r_exception <= 1'b0;
      end else if (bus.redirect) begin
         // Everything still outstanding after this edge belongs to the old path.
         r_fetchPc   <= bus.redirect_pc;
         r_pcTag     <= bus.redirect_pc;
         r_count     <= '0;
         r_rdPtr     <= '0;
         r_wrPtr     <= '0;
         r_inflight  <= r_inflight - CW'(w_respIn);
         r_drop      <= r_inflight - CW'(w_respIn);
         r_exception <= |bus.redirect_pc[1:0];
      end else begin
         if (w_reqFire) begin
            r_fetchPc <= r_fetchPc + XLEN'(4);
         end
         r_inflight <= r_inflight + CW'(w_reqFire) - CW'(w_respIn);
         if (w_respIn && (r_drop != '0)) begin
            r_drop <= r_drop - CW'(1);
         end
         if (w_push) begin
            r_pcTag <= r_pcTag + XLEN'(4);
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifoInstr[r_wrPtr] <= bus.mem_resp_data;
         r_fifoAddr[r_wrPtr]  <= r_pcTag;
      end
   end

   a_respHasRequest: assert property (@(posedge clk) disable iff (rst)
      bus.mem_resp_valid |-> (r_inflight != '0));
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: directed vector table, corner-case sequences and a randomized
// run against a queue-based model of memory, outstanding fetches and the instruction buffer.
module tb_riscv_fetch_unit;
   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] NONE     = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rst;

   riscv_fetch_unit_if #(.XLEN(XLEN)) bus ();

   riscv_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int nVec;
   int nErr;
   int cyc;
   int latMin;
   int latMax;
   int memReadyPct;

   logic [31:0] pendAddr [$];
   int          pendDue  [$];
   bit          pendLive [$];
   logic [31:0] fifoAddr [$];
   logic [31:0] fifoData [$];
   logic [31:0] expPc;
   bit          expExc;

   bit          obsReqFire;
   bit          obsValid;
   bit          obsPop;
   bit          obsExc;
   logic [31:0] obsReqAddr;
   logic [31:0] obsInstrAddr;

   typedef struct {
      int          lat;
      bit          memReady;
      bit          coreReady;
      bit          doRedirect;
      logic [31:0] rdPc;
      int          cycles;
      int          expReqs;
      logic [31:0] expFirstAddr;
      int          expFirstValid;
      bit          expExc;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return {addr[15:0] ^ 16'h5A3C, addr[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compareModel();
      bit expReq;
      expReq = !rst && !bus.redirect && !expExc && ((fifoAddr.size() + pendAddr.size()) < DEPTH);
      checkOutput("mem_req_valid", 32'(bus.mem_req_valid), 32'(expReq));
      if (expReq) checkOutput("mem_req_addr", bus.mem_req_addr, expPc);
      checkOutput("instr_valid", 32'(bus.instr_valid), 32'(fifoAddr.size() != 0));
      if (fifoAddr.size() != 0) begin
         checkOutput("instr_addr", bus.instr_addr, fifoAddr[0]);
         checkOutput("instruction", bus.instruction, fifoData[0]);
      end
      checkOutput("exception", 32'(bus.exception), 32'(expExc));
   endtask

   // One clock cycle: memory drives its side, outputs are checked mid-cycle, model advances.
   task automatic applyStimulus(input bit chk);
      bit          resp;
      bit          live;
      bit          pop;
      bit          fire;
      logic [31:0] rAddr;
      int          due;
      live  = 1'b0;
      rAddr = '0;
      bus.mem_req_ready = (int'($urandom_range(99)) < memReadyPct);
      resp = !rst && (pendDue.size() != 0) && (pendDue[0] <= cyc);
      bus.mem_resp_valid = resp;
      if (resp) bus.mem_resp_data = memWord(pendAddr[0]);
      else      bus.mem_resp_data = $urandom();
      #1;
      if (chk) compareModel();
      fire         = bus.mem_req_valid && bus.mem_req_ready;
      obsReqFire   = fire;
      obsReqAddr   = bus.mem_req_addr;
      obsValid     = bus.instr_valid;
      obsInstrAddr = bus.instr_addr;
      obsPop       = bus.instr_valid && bus.instr_ready;
      obsExc       = bus.exception;
      pop          = bus.instr_ready && (fifoAddr.size() != 0);
      if (rst) begin
         pendAddr.delete(); pendDue.delete(); pendLive.delete();
         fifoAddr.delete(); fifoData.delete();
         expPc  = RESET_PC;
         expExc = 1'b0;
      end else begin
         if (resp) begin
            rAddr = pendAddr.pop_front();
            live  = pendLive.pop_front();
            void'(pendDue.pop_front());
         end
         if (fire) begin
            due = cyc + latMin + int'($urandom_range(latMax - latMin));
            if (pendDue.size() != 0 && pendDue[$] > due) due = pendDue[$];
            pendAddr.push_back(bus.mem_req_addr);
            pendDue.push_back(due);
            pendLive.push_back(!bus.redirect);
            expPc = expPc + 32'd4;
         end
         if (bus.redirect) begin
            fifoAddr.delete(); fifoData.delete();
            foreach (pendLive[i]) pendLive[i] = 1'b0;
            expPc  = bus.redirect_pc;
            expExc = |bus.redirect_pc[1:0];
         end else begin
            if (pop) begin
               void'(fifoAddr.pop_front());
               void'(fifoData.pop_front());
            end
            if (resp && live) begin
               fifoAddr.push_back(rAddr);
               fifoData.push_back(memWord(rAddr));
            end
         end
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset();
      rst             = 1'b1;
      bus.redirect    = 1'b0;
      bus.instr_ready = 1'b0;
      applyStimulus(1'b0);
      #1;
      checkOutput("reset mem_req_valid", 32'(bus.mem_req_valid), 32'h0);
      checkOutput("reset instr_valid", 32'(bus.instr_valid), 32'h0);
      checkOutput("reset instruction", bus.instruction, 32'h0);
      checkOutput("reset instr_addr", bus.instr_addr, 32'h0);
      checkOutput("reset exception", 32'(bus.exception), 32'h0);
      applyStimulus(1'b1);
      rst = 1'b0;
   endtask

   initial begin
      int          reqs;
      int          firstValid;
      int          nPops;
      int          stale;
      int          r;
      logic [31:0] firstAddr;
      logic [31:0] resumeAddr;
      logic [31:0] pc;
      logic [31:0] drained [4];

      nVec = 0; nErr = 0; cyc = 0;
      latMin = 1; latMax = 1; memReadyPct = 100;
      rst = 1'b1;
      bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
      expPc = RESET_PC; expExc = 1'b0;

      vecs[0] = '{1, 1'b1, 1'b1, 1'b0, 32'h0,         10, 10, 32'h0,         2,  1'b0};
      vecs[1] = '{1, 1'b1, 1'b0, 1'b0, 32'h0,         12, 4,  32'h0,         2,  1'b0};
      vecs[2] = '{1, 1'b1, 1'b1, 1'b1, 32'h102,       8,  0,  32'h0,         -1, 1'b1};
      vecs[3] = '{1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 6,  5,  32'hFFFF_FFF8, 3,  1'b0};
      vecs[4] = '{1, 1'b0, 1'b1, 1'b0, 32'h0,         6,  0,  32'h0,         -1, 1'b0};
      vecs[5] = '{2, 1'b1, 1'b1, 1'b0, 32'h0,         10, 10, 32'h0,         3,  1'b0};

      @(negedge clk);
      for (int v = 0; v < 6; v++) begin
         doReset();
         latMin = vecs[v].lat; latMax = vecs[v].lat;
         memReadyPct = vecs[v].memReady ? 100 : 0;
         reqs = 0; firstAddr = NONE; firstValid = -1;
         for (int c = 0; c < vecs[v].cycles; c++) begin
            bus.redirect    = vecs[v].doRedirect && (c == 0);
            bus.redirect_pc = vecs[v].rdPc;
            bus.instr_ready = vecs[v].coreReady;
            applyStimulus(1'b1);
            if (obsReqFire) begin
               if (reqs == 0) firstAddr = obsReqAddr;
               reqs++;
            end
            if (obsValid && firstValid < 0) firstValid = c;
         end
         bus.redirect = 1'b0;
         checkOutput($sformatf("vec%0d requests", v), 32'(reqs), 32'(vecs[v].expReqs));
         checkOutput($sformatf("vec%0d first valid cycle", v), 32'(firstValid), 32'(vecs[v].expFirstValid));
         checkOutput($sformatf("vec%0d exception", v), 32'(obsExc), 32'(vecs[v].expExc));
         if (vecs[v].expReqs > 0) checkOutput($sformatf("vec%0d first addr", v), firstAddr, vecs[v].expFirstAddr);
      end
      memReadyPct = 100; latMin = 1; latMax = 1;

      // Full FIFO with a stalled core, then drain in order and resume at 0x10.
      doReset();
      for (int c = 0; c < 8; c++) applyStimulus(1'b1);
      checkOutput("stalled no request", 32'(obsReqFire), 32'h0);
      bus.instr_ready = 1'b1;
      nPops = 0; resumeAddr = NONE;
      for (int k = 0; k < 4; k++) drained[k] = NONE;
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b1);
         if (obsPop && nPops < 4) begin
            drained[nPops] = obsInstrAddr;
            nPops++;
         end
         if (obsReqFire && resumeAddr == NONE) resumeAddr = obsReqAddr;
      end
      for (int k = 0; k < 4; k++) checkOutput($sformatf("drain[%0d]", k), drained[k], 32'(4 * k));
      checkOutput("resume addr", resumeAddr, 32'h10);

      // Latency 3, redirect with two fetches outstanding.
      doReset();
      latMin = 3; latMax = 3; bus.instr_ready = 1'b1;
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
      applyStimulus(1'b1);
      bus.redirect = 1'b0;
      checkOutput("redirect blocks request", 32'(obsReqFire), 32'h0);
      firstAddr = NONE; stale = 0;
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b1);
         if (obsValid) begin
            if (firstAddr == NONE) firstAddr = obsInstrAddr;
            if (obsInstrAddr < 32'h100) stale++;
         end
      end
      checkOutput("post-redirect first pc", firstAddr, 32'h100);
      checkOutput("stale words seen", 32'(stale), 32'h0);

      // Redirect colliding with a pop and a response.
      doReset();
      latMin = 1; latMax = 1; bus.instr_ready = 1'b1;
      for (int c = 0; c < 3; c++) applyStimulus(1'b1);
      bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
      applyStimulus(1'b1);
      bus.redirect = 1'b0;
      checkOutput("pop during redirect", 32'(obsPop), 32'h1);
      applyStimulus(1'b1);
      checkOutput("flushed after redirect", 32'(obsValid), 32'h0);
      checkOutput("first request after redirect", obsReqFire ? obsReqAddr : NONE, 32'h40);

      // Misaligned redirect, then recovery through an aligned one.
      doReset();
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      bus.redirect = 1'b1; bus.redirect_pc = 32'h102;
      applyStimulus(1'b1);
      bus.redirect = 1'b0;
      reqs = 0;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1);
         if (obsReqFire) reqs++;
      end
      checkOutput("exception raised", 32'(obsExc), 32'h1);
      checkOutput("no fetch while excepted", 32'(reqs), 32'h0);
      bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
      applyStimulus(1'b1);
      bus.redirect = 1'b0;
      applyStimulus(1'b1);
      checkOutput("exception cleared", 32'(obsExc), 32'h0);
      checkOutput("resume at 0x200", obsReqFire ? obsReqAddr : NONE, 32'h200);

      // Reset while the FIFO holds three entries.
      doReset();
      bus.instr_ready = 1'b0;
      for (int c = 0; c < 4; c++) applyStimulus(1'b1);
      rst = 1'b1;
      applyStimulus(1'b1);
      checkOutput("valid before mid reset", 32'(obsValid), 32'h1);
      rst = 1'b0;
      applyStimulus(1'b1);
      checkOutput("valid after mid reset", 32'(obsValid), 32'h0);
      checkOutput("restart pc", obsReqFire ? obsReqAddr : NONE, RESET_PC);

      // Randomized traffic: variable latency, backpressure, redirects and occasional resets.
      doReset();
      latMin = 1; latMax = 4; memReadyPct = 70;
      for (int c = 0; c < 3000; c++) begin
         r   = int'($urandom_range(999));
         rst = (r < 3);
         bus.redirect = !rst && (r >= 3) && (r < 33);
         pc = $urandom();
         if ($urandom_range(3) != 0) pc[1:0] = 2'b00;
         if ($urandom_range(7) == 0) pc = {28'hFFF_FFFF, pc[3:0]};
         bus.redirect_pc = pc;
         bus.instr_ready = ($urandom_range(9) < 6);
         applyStimulus(1'b1);
      end
      rst = 1'b0;
      bus.redirect = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
